lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
- Load/store execution stage directly downstream of the memory reservation station (MEM RS).
- Consumes the head entry once both operands are valid, computes the effective address (val + imm), and owns the data memory array.
- Performs stores immediately. Returns load results on the LW broadcast bus (we_LW/tag_LW/val_LW), which feeds every RS and the register/ROB write path.
- Drives `stop` back to the MEM RS so that it holds a load while the unit is busy.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory.
- ADDR_W, 8, word-index width; DEPTH = 2**ADDR_W.
- LOAD_LAT, 2, cycles from load acceptance edge to result broadcast; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- lw_i  in  1  head entry is a load with operands ready.
- sw_i  in  1  head entry is a store with operands ready.
- dst_i  in  5  architectural destination of load.
- dst_tag_i  in  5  rename tag of load result.
- imm_i  in  32  offset.
- val_i  in  32  base register value.
- data_i  in  32  store data.
- stop  out  1  load-busy back-pressure to MEM RS.
- we_LW  out  1  load result broadcast valid (one cycle).
- tag_LW  out  5  broadcast tag.
- dst_LW  out  5  broadcast architectural destination.
- val_LW  out  32  loaded word.

Behaviour:
- Effective address: ea = val_i + imm_i, 32-bit wrap.
- Word index: ea[ADDR_W+1:2]. ea[1:0] is ignored, and upper bits are ignored (aliasing).
- FSM states:
  - IDLE
  - WAIT: internal counter cnt, 4 bits.
  - RESP: we_LW=1.
- stop = (state == WAIT), purely combinational from state. It is 0 in IDLE and RESP.
- Load acceptance: lw_i=1 with state IDLE or RESP.
  - At that edge, capture mem[idx], dst_tag_i, dst_i.
  - If LOAD_LAT=1, go to RESP; otherwise go to WAIT with cnt=LOAD_LAT-2.
- WAIT: decrement cnt each edge; when cnt==0, go to RESP.
- RESP: we_LW=1, tag_LW/dst_LW/val_LW hold the captured values.
  - Next state is WAIT/RESP if a new load is accepted, otherwise IDLE.
- Result timing: we_LW is high in exactly one cycle, the LOAD_LAT-th cycle after the acceptance edge.
- Throughput: back-to-back loads issue one per LOAD_LAT cycles.
- lw_i while in WAIT is ignored. The RS holds the entry because stop=1, so there is no loss.
- Stores:
  - sw_i=1 writes mem[idx] <= data_i at the edge, in any state, including WAIT. Stores never touch the FSM.
  - No broadcast for stores.
- Ordering:
  - A load accepted at the edge after a store's edge observes the stored value.
  - A store during a pending load does not alter the already captured load data.
- lw_i and sw_i both high is illegal. Required handling: perform the store and ignore the load.
- Outputs are zero/low when not in RESP except val_LW/tag_LW/dst_LW, which hold their last values.
- Reset (asynchronous, mid-operation included):
  - state=IDLE, cnt=0, stop=0, we_LW=0, tag_LW=0, dst_LW=0, val_LW=0.
  - An in-flight load is discarded.
  - Memory contents are not reset.

Optional Feature:
- Macro LSU_MISALIGN_CHK_EN.
- When defined:
  - Adds output port misalign (1 bit, registered, one-cycle pulse) set when an accepted load or a store has ea[1:0] != 0.
  - A misaligned store is dropped (memory unchanged).
  - A misaligned load still broadcasts, with val_LW = 32'h0.
- When undefined: no port is added, and ea[1:0] is silently ignored as above.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - TAG_W=5, REG_W=5, XLEN=32.
- One natural sub-module: lsu_dmem (single write port, registered read, DEPTH x 32, no reset). The FSM and address generation stay in the top.

Test Plan:
- Reset, then idle → stop=0, we_LW=0. Assert rst mid-WAIT → next cycle is IDLE with we_LW=0, and the pending result never appears.
- Store: sw_i, val=0x10, imm=0x4, data=0xDEADBEEF. Next cycle lw_i, val=0x14, imm=0, tag=7, dst=3 → after 2 cycles: we_LW=1, tag_LW=7, dst_LW=3, val_LW=0xDEADBEEF, for exactly one cycle.
- Two loads presented continuously (LOAD_LAT=2) → stop=1 during WAIT. The second load is accepted in the RESP cycle of the first, and the broadcasts appear 2 cycles apart.
- Load pending (tag=4, addr 0x20 holds 0x11). Store 0x22 to 0x20 during WAIT → broadcast val_LW=0x11. A subsequent load of 0x20 returns 0x22.
- LOAD_LAT=1 build: loads on consecutive cycles → we_LW high every cycle, stop never asserted.
- Address wrap: val=0xFFFFFFFC, imm=0x8 → ea=0x4, index 1. With LSU_MISALIGN_CHK_EN, a store to ea=0x2 → misalign=1 and the memory is unchanged.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// Shared types and widths for the load/store memory stage.
package lsu_mem_stage_pkg;

    localparam int unsigned TAG_W = 5;
    localparam int unsigned REG_W = 5;
    localparam int unsigned XLEN  = 32;

    // Load-pipeline FSM encoding.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Request/broadcast bus between the MEM RS head and the load/store stage.
// Optional LSU_MISALIGN_CHK_EN adds the misalign flag.
interface lsu_mem_stage_if;
    import lsu_mem_stage_pkg::*;

    logic             lw_i;
    logic             sw_i;
    logic [REG_W-1:0] dst_i;
    logic [TAG_W-1:0] dst_tag_i;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  val_i;
    logic [XLEN-1:0]  data_i;
    logic             stop;
    logic             we_LW;
    logic [TAG_W-1:0] tag_LW;
    logic [REG_W-1:0] dst_LW;
    logic [XLEN-1:0]  val_LW;
`ifdef LSU_MISALIGN_CHK_EN
    logic             misalign;
`endif

    // Reservation-station side.
    modport master (
        output lw_i, sw_i, dst_i, dst_tag_i, imm_i, val_i, data_i,
`ifdef LSU_MISALIGN_CHK_EN
        input  misalign,
`endif
        input  stop, we_LW, tag_LW, dst_LW, val_LW
    );

    // Load/store stage side.
    modport slave (
        input  lw_i, sw_i, dst_i, dst_tag_i, imm_i, val_i, data_i,
`ifdef LSU_MISALIGN_CHK_EN
        output misalign,
`endif
        output stop, we_LW, tag_LW, dst_LW, val_LW
    );

endinterface

// File: rtl/lsu_mem_stage_dmem.sv
// Data memory (lsu_dmem): DEPTH x 32, single write port, enabled registered read, no reset.
module lsu_mem_stage_dmem
    import lsu_mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [XLEN-1:0]   rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] rdata_q;

    // Write on store; read register only loads on acceptance so later stores cannot disturb it.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store execution stage: address generation, load FSM and LW broadcast.
// Optional LSU_MISALIGN_CHK_EN: flag misaligned accesses, drop misaligned stores,
// broadcast zero for misaligned loads.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned LOAD_LAT = 2
) (
    input logic            clk,
    input logic            rst,
    lsu_mem_stage_if.slave bus
);

    localparam logic [3:0] CntInit = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

    lsu_state_e       state_q;
    logic [3:0]       cnt_q;
    logic             we_q;
    logic [TAG_W-1:0] tag_q;
    logic [REG_W-1:0] dst_q;
    logic             has_data_q;
    logic [ADDR_W-1:0] idx;
    logic             ld_acc;
    logic             st_en;
    logic             rd_ok;
    logic [XLEN-1:0]  rdata;

    // Word index of val + imm; byte offset and upper bits drop out (aliasing).
    assign idx = ADDR_W'((bus.val_i + bus.imm_i) >> 2);

    // A simultaneous store wins; loads are held off while waiting.
    assign ld_acc = bus.lw_i && !bus.sw_i && (state_q != StWait);

`ifdef LSU_MISALIGN_CHK_EN
    logic [1:0] ea_lo;
    logic       misalign_q;
    logic       mis_ld_q;

    assign ea_lo = bus.val_i[1:0] + bus.imm_i[1:0];
    assign st_en = bus.sw_i && (ea_lo == 2'b00);

    // One-cycle misalign pulse; remember whether the in-flight load was misaligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
            mis_ld_q   <= 1'b0;
        end else begin
            misalign_q <= (ld_acc || bus.sw_i) && (ea_lo != 2'b00);
            if (ld_acc) begin
                mis_ld_q <= (ea_lo != 2'b00);
            end
        end
    end

    assign bus.misalign = misalign_q;
    assign rd_ok        = has_data_q && !mis_ld_q;
`else
    assign st_en = bus.sw_i;
    assign rd_ok = has_data_q;
`endif

    lsu_mem_stage_dmem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk     (clk),
        .we_i    (st_en),
        .re_i    (ld_acc),
        .addr_i  (idx),
        .wdata_i (bus.data_i),
        .rdata_o (rdata)
    );

    // Load FSM with registered broadcast valid and captured tag/destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            tag_q      <= '0;
            dst_q      <= '0;
            has_data_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                StIdle, StResp: begin
                    if (ld_acc) begin
                        tag_q      <= bus.dst_tag_i;
                        dst_q      <= bus.dst_i;
                        has_data_q <= 1'b1;
                        if (LOAD_LAT == 1) begin
                            state_q <= StResp;
                            we_q    <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CntInit;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StResp;
                        we_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.stop   = (state_q == StWait);
    assign bus.we_LW  = we_q;
    assign bus.tag_LW = tag_q;
    assign bus.dst_LW = dst_q;
    assign bus.val_LW = rd_ok ? rdata : '0;

endmodule
